// File: rtl/alu_pkg.sv
// Shared constants and types for the ALU operand-fetch stage.
package alu_pkg;

  localparam int WIDTH = 32;
  localparam int NREGS = 32;
  localparam int AW    = $clog2(NREGS);

  typedef enum logic {
    OF_EMPTY = 1'b0,
    OF_FULL  = 1'b1
  } opfetch_state_t;

endpackage

// File: rtl/alu_regfile_2r1w.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port. Register 0 reads as zero and ignores writes.
module alu_regfile_2r1w
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    ra_i,
  input  logic [AW-1:0]    rb_i,
  output logic [WIDTH-1:0] rdata_a_o,
  output logic [WIDTH-1:0] rdata_b_o
);

  logic [WIDTH-1:0] regs_q [NREGS];

  // NOTE: the architectural state must come out of reset as all-zero, so the
  // array is cleared entry by entry; this rules out a plain RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en_i && (wr_addr_i != '0)) begin
      regs_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rdata_a_o = (ra_i == '0) ? '0 : regs_q[ra_i];
  assign rdata_b_o = (rb_i == '0) ? '0 : regs_q[rb_i];

endmodule

// File: rtl/alu_operand_fetch.sv
// Register file plus one-deep operand buffer feeding the ALU with valid/ready.
// Define OPFETCH_FWD_EN to bypass same-cycle write-back data into captured operands.
module alu_operand_fetch
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AW-1:0]    req_ra,
  input  logic [AW-1:0]    req_rb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [15:0]      stall_cnt
);

  opfetch_state_t   state_q, state_d;
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic [15:0]      stall_cnt_q, stall_cnt_d;
  logic [WIDTH-1:0] rd_a, rd_b;
  logic [WIDTH-1:0] src_a, src_b;
  logic             accept;

  alu_regfile_2r1w u_regfile (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .ra_i      (req_ra),
    .rb_i      (req_rb),
    .rdata_a_o (rd_a),
    .rdata_b_o (rd_b)
  );

  assign accept = req_valid && req_ready;

  // NOTE: state is updated only with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= OF_EMPTY;
      out_a_q     <= '0;
      out_b_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      OF_EMPTY: if (req_valid) state_d = OF_FULL;
      OF_FULL:  if (out_ready) state_d = req_valid ? OF_FULL : OF_EMPTY;
      default:  state_d = OF_EMPTY;
    endcase
  end

  // A write landing on a source register in the accept cycle is either
  // bypassed or left to software (one bubble), depending on the build.
  always_comb begin
    src_a = rd_a;
    src_b = rd_b;
`ifdef OPFETCH_FWD_EN
    if (wr_en && (wr_addr != '0) && (wr_addr == req_ra)) src_a = wr_data;
    if (wr_en && (wr_addr != '0) && (wr_addr == req_rb)) src_b = wr_data;
`endif
    out_a_d = accept ? src_a : out_a_q;
    out_b_d = accept ? src_b : out_b_q;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((state_q == OF_FULL) && !out_ready && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_comb begin
    out_valid = (state_q == OF_FULL);
    req_ready = (state_q != OF_FULL) || out_ready;
  end

  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign stall_cnt = stall_cnt_q;

endmodule
